// File: rtl/serial_frame_deserializer.sv
// Start-bit framed serial-to-parallel converter: hunts for a start bit, shifts
// WORDS_PER_FRAME words and hands each one out through a valid/ready register.
module serial_frame_deserializer #(
    parameter int   WORD_SIZE       = 8,
    parameter int   WORDS_PER_FRAME = 2,
    parameter int   CLKS_PER_BIT    = 1,
    parameter logic START_BIT       = 1'b0,
    parameter bit   MSB_FIRST       = 1'b0,
    localparam int  INDEX_W         = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 data_in,
    output logic [WORD_SIZE-1:0] word_out,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic [INDEX_W-1:0]   word_index,
    output logic                 word_last,
    output logic                 frame_done,
    output logic                 overflow,
    output logic                 busy
);

    localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(WORD_SIZE + 1);
    localparam int WORD_W = $clog2(WORDS_PER_FRAME + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_SIZE - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS_PER_FRAME - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        SHIFT
    } state_t;

    state_t                state_q, state_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic [WORD_SIZE-1:0]  shreg_q, shreg_d;
    logic [WORD_SIZE-1:0]  word_out_d;
    logic                  word_valid_d;
    logic [INDEX_W-1:0]    word_index_d;
    logic                  word_last_d;
    logic                  frame_done_d;
    logic                  overflow_d;

    logic [WORD_SIZE-1:0]  shifted;
    logic                  consume;
    logic                  capture;

    assign shifted = MSB_FIRST ? {shreg_q[WORD_SIZE-2:0], data_in}
                               : {data_in, shreg_q[WORD_SIZE-1:1]};
    assign consume = word_valid && word_ready;
    assign busy    = (state_q != IDLE) || start;

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
        state_d      = state_q;
        tick_d       = tick_q;
        bit_d        = bit_q;
        word_d       = word_q;
        shreg_d      = shreg_q;
        word_out_d   = word_out;
        word_valid_d = word_valid && !consume;
        word_index_d = word_index;
        word_last_d  = word_last;
        frame_done_d = 1'b0;
        overflow_d   = overflow;
        capture      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ARMED;
                    overflow_d = 1'b0;
                end
            end
            ARMED: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (data_in == START_BIT) begin
                    state_d = SHIFT;
                    tick_d  = '0;
                    bit_d   = '0;
                    word_d  = '0;
                    shreg_d = '0;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    tick_d  = '0;
                    bit_d   = '0;
                    word_d  = '0;
                end else begin
                    tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
                    if (tick_q == TICK_LAST) begin
                        shreg_d = shifted;
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            word_d  = word_q + 1'b1;
                            capture = 1'b1;
                            if (word_q == WORD_LAST) begin
                                frame_done_d = 1'b1;
                                state_d      = IDLE;
                            end
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A completed word may only replace the held one if it is empty or leaving now.
        if (capture) begin
            if (!word_valid || consume) begin
                word_out_d   = shifted;
                word_index_d = INDEX_W'(word_q);
                word_last_d  = (word_q == WORD_LAST);
                word_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_q     <= '0;
            bit_q      <= '0;
            word_q     <= '0;
            shreg_q    <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            word_index <= '0;
            word_last  <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            word_q     <= word_d;
            shreg_q    <= shreg_d;
            word_out   <= word_out_d;
            word_valid <= word_valid_d;
            word_index <= word_index_d;
            word_last  <= word_last_d;
            frame_done <= frame_done_d;
            overflow   <= overflow_d;
        end
    end

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed and randomized bench for serial_frame_deserializer: one LSB-first single-rate
// instance and one MSB-first, four-clocks-per-bit instance, checked against a bit-list model.
module tb_serial_frame_deserializer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       a_start, a_abort, a_data, a_ready;
    logic [7:0] a_word;
    logic       a_valid, a_index, a_last, a_done, a_ovf, a_busy;
    logic       b_start, b_abort, b_data, b_ready;
    logic [7:0] b_word;
    logic       b_valid, b_index, b_last, b_done, b_ovf, b_busy;

    int checks   = 0;
    int failures = 0;
    int a_done_n = 0;
    int b_done_n = 0;
    logic [9:0] a_q[$];
    logic [9:0] b_q[$];

    serial_frame_deserializer #(
        .WORD_SIZE(8), .WORDS_PER_FRAME(2), .CLKS_PER_BIT(1), .START_BIT(1'b0), .MSB_FIRST(1'b0)
    ) dut_a (
        .clock(clock), .reset(reset), .start(a_start), .abort(a_abort), .data_in(a_data),
        .word_out(a_word), .word_valid(a_valid), .word_ready(a_ready), .word_index(a_index),
        .word_last(a_last), .frame_done(a_done), .overflow(a_ovf), .busy(a_busy)
    );

    serial_frame_deserializer #(
        .WORD_SIZE(8), .WORDS_PER_FRAME(2), .CLKS_PER_BIT(4), .START_BIT(1'b0), .MSB_FIRST(1'b1)
    ) dut_b (
        .clock(clock), .reset(reset), .start(b_start), .abort(b_abort), .data_in(b_data),
        .word_out(b_word), .word_valid(b_valid), .word_ready(b_ready), .word_index(b_index),
        .word_last(b_last), .frame_done(b_done), .overflow(b_ovf), .busy(b_busy)
    );

    // Transfer log: every valid/ready handshake and every frame_done cycle.
    always @(posedge clock) begin
        if (!reset && a_valid && a_ready) a_q.push_back({a_index, a_last, a_word});
        if (!reset && b_valid && b_ready) b_q.push_back({b_index, b_last, b_word});
        if (!reset && a_done) a_done_n++;
        if (!reset && b_done) b_done_n++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Word assembled from time-ordered line bits starting at bit position base.
    function automatic logic [7:0] model_word(input logic [31:0] bits, input int base, input bit msb_first);
        logic [7:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            if (msb_first) w[7-i] = bits[base+i];
            else           w[i]   = bits[base+i];
        end
        return w;
    endfunction

    task automatic a_expect(input string tag, input logic [7:0] word, input logic idx, input logic last);
        check({tag, "_present"}, 32'(a_q.size() > 0), 32'd1);
        if (a_q.size() > 0) check(tag, 32'(a_q.pop_front()), 32'({idx, last, word}));
    endtask

    task automatic b_expect(input string tag, input logic [7:0] word, input logic idx, input logic last);
        check({tag, "_present"}, 32'(b_q.size() > 0), 32'd1);
        if (b_q.size() > 0) check(tag, 32'(b_q.pop_front()), 32'({idx, last, word}));
    endtask

    // start pulse, idle line 1,1, start bit 0, then n data bits (bits[0] first).
    task automatic a_send(input logic [31:0] bits, input int n, input bit pulse_last, input int start_at);
        a_start = 1'b1;
        a_data  = 1'b1;
        step();
        a_start = 1'b0;
        step();
        step();
        a_data = 1'b0;
        step();
        for (int i = 0; i < n; i++) begin
            a_data  = bits[i];
            a_start = (i == start_at);
            if (pulse_last && i == n - 1) a_ready = 1'b1;
            step();
            a_start = 1'b0;
            if (pulse_last) a_ready = 1'b0;
        end
        a_data = 1'b1;
    endtask

    // Each bit occupies four cycles; with glitch set only the fourth cycle carries the true bit.
    task automatic b_send(input logic [31:0] bits, input bit glitch);
        b_start = 1'b1;
        b_data  = 1'b1;
        step();
        b_start = 1'b0;
        step();
        b_data = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            for (int c = 0; c < 4; c++) begin
                b_data = (glitch && c != 3) ? ~bits[i] : bits[i];
                step();
            end
        end
        b_data = 1'b1;
    endtask

    initial begin
        logic [31:0] bits;
        int          n0;

        reset   = 1'b1;
        a_start = 1'b0; a_abort = 1'b0; a_data = 1'b1; a_ready = 1'b0;
        b_start = 1'b0; b_abort = 1'b0; b_data = 1'b1; b_ready = 1'b0;
        step();
        step();
        check("rst_word",  32'(a_word),  32'h0);
        check("rst_valid", 32'(a_valid), 32'h0);
        check("rst_index", 32'(a_index), 32'h0);
        check("rst_last",  32'(a_last),  32'h0);
        check("rst_done",  32'(a_done),  32'h0);
        check("rst_ovf",   32'(a_ovf),   32'h0);
        check("rst_busy",  32'(a_busy),  32'h0);
        check("rst_b_valid", 32'(b_valid), 32'h0);
        reset = 1'b0;
        step();

        // Basic LSB-first frame 0xA5, 0x3C with free-flowing consumer.
        a_ready = 1'b1;
        n0 = a_done_n;
        a_send(32'h0000_3CA5, 16, 1'b0, -1);
        check("t1_done_pulse", 32'(a_done), 32'h1);
        check("t1_busy_low",   32'(a_busy), 32'h0);
        step();
        step();
        a_expect("t1_w0", 8'hA5, 1'b0, 1'b0);
        a_expect("t1_w1", 8'h3C, 1'b1, 1'b1);
        check("t1_done_count", 32'(a_done_n - n0), 32'd1);
        check("t1_ovf",   32'(a_ovf),   32'h0);
        check("t1_valid", 32'(a_valid), 32'h0);

        // MSB-first at four clocks per bit: held bits, then exact sample-point frames.
        b_ready = 1'b1;
        bits = {16'h0, 8'($urandom), 8'hA5};
        b_send(bits, 1'b0);
        check("t2_done_pulse", 32'(b_done), 32'h1);
        step();
        b_expect("t2_w0", 8'hA5, 1'b0, 1'b0);
        b_expect("t2_w1", model_word(bits, 8, 1'b1), 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            bits = $urandom;
            b_send(bits, 1'b1);
            step();
            b_expect("t2_glitch_w0", model_word(bits, 0, 1'b1), 1'b0, 1'b0);
            b_expect("t2_glitch_w1", model_word(bits, 8, 1'b1), 1'b1, 1'b1);
        end
        check("t2_ovf", 32'(b_ovf), 32'h0);

        // Back-pressure for the whole frame: word 0 held, word 1 dropped.
        a_ready = 1'b0;
        bits = $urandom;
        n0 = a_done_n;
        a_send(bits, 16, 1'b0, -1);
        check("t3_done_pulse", 32'(a_done),  32'h1);
        check("t3_valid",      32'(a_valid), 32'h1);
        check("t3_word",       32'(a_word),  32'(model_word(bits, 0, 1'b0)));
        check("t3_index",      32'(a_index), 32'h0);
        check("t3_last",       32'(a_last),  32'h0);
        check("t3_ovf",        32'(a_ovf),   32'h1);
        step();
        check("t3_done_count", 32'(a_done_n - n0), 32'd1);
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        check("t3_ovf_cleared", 32'(a_ovf),  32'h0);
        check("t3_armed_busy",  32'(a_busy), 32'h1);
        a_abort = 1'b1;
        step();
        a_abort = 1'b0;
        check("t3_abort_idle",   32'(a_busy),  32'h0);
        check("t3_abort_keeps",  32'(a_valid), 32'h1);
        a_ready = 1'b1;
        step();
        check("t3_drained", 32'(a_valid), 32'h0);
        a_expect("t3_w0", model_word(bits, 0, 1'b0), 1'b0, 1'b0);

        // Consumer accepts word 0 on the very edge word 1 completes.
        a_ready = 1'b0;
        bits = $urandom;
        a_send(bits, 16, 1'b1, -1);
        a_expect("t4_w0", model_word(bits, 0, 1'b0), 1'b0, 1'b0);
        check("t4_word",  32'(a_word),  32'(model_word(bits, 8, 1'b0)));
        check("t4_index", 32'(a_index), 32'h1);
        check("t4_last",  32'(a_last),  32'h1);
        check("t4_valid", 32'(a_valid), 32'h1);
        check("t4_ovf",   32'(a_ovf),   32'h0);
        a_ready = 1'b1;
        step();
        a_expect("t4_w1", model_word(bits, 8, 1'b0), 1'b1, 1'b1);
        check("t4_valid_after", 32'(a_valid), 32'h0);

        // Abort after five data bits, then a clean all-ones frame.
        n0 = a_done_n;
        a_send(32'h0000_001F, 5, 1'b0, -1);
        a_abort = 1'b1;
        step();
        a_abort = 1'b0;
        check("t5_idle",  32'(a_busy),  32'h0);
        check("t5_valid", 32'(a_valid), 32'h0);
        check("t5_done",  32'(a_done),  32'h0);
        step();
        check("t5_done_count", 32'(a_done_n - n0), 32'd0);
        a_send(32'h0000_FFFF, 16, 1'b0, -1);
        step();
        a_expect("t5_w0", 8'hFF, 1'b0, 1'b0);
        a_expect("t5_w1", 8'hFF, 1'b1, 1'b1);

        // Reset in the middle of word 1 while word 0 is held.
        a_ready = 1'b0;
        bits = $urandom;
        a_send(bits, 12, 1'b0, -1);
        check("t6_pre_valid", 32'(a_valid), 32'h1);
        check("t6_pre_word",  32'(a_word),  32'(model_word(bits, 0, 1'b0)));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_word",  32'(a_word),  32'h0);
        check("t6_valid", 32'(a_valid), 32'h0);
        check("t6_index", 32'(a_index), 32'h0);
        check("t6_last",  32'(a_last),  32'h0);
        check("t6_done",  32'(a_done),  32'h0);
        check("t6_ovf",   32'(a_ovf),   32'h0);
        check("t6_busy",  32'(a_busy),  32'h0);

        // start pulsed mid-frame must not restart the hunt.
        a_ready = 1'b1;
        bits = $urandom;
        a_send(bits, 16, 1'b0, 4);
        step();
        a_expect("t6_w0", model_word(bits, 0, 1'b0), 1'b0, 1'b0);
        a_expect("t6_w1", model_word(bits, 8, 1'b0), 1'b1, 1'b1);

        // Random frames through the single-rate instance.
        for (int k = 0; k < 4; k++) begin
            bits = $urandom;
            a_send(bits, 16, 1'b0, -1);
            step();
            a_expect("rnd_w0", model_word(bits, 0, 1'b0), 1'b0, 1'b0);
            a_expect("rnd_w1", model_word(bits, 8, 1'b0), 1'b1, 1'b1);
        end
        check("final_a_queue", 32'(a_q.size()), 32'd0);
        check("final_b_queue", 32'(b_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
